// File: rtl/cim_result_collector.sv
// cim_result_collector: captures CIM stage-4 results, requantizes (ReLU, shift, saturate) and buffers them in a FWFT FIFO.
module cim_result_collector #(
  parameter int IN_WIDTH    = 22,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          done,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          enable,
  input  logic                          relu_en,
  input  logic [SHIFT_WIDTH-1:0]        shift_amt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          sat_flag,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          result_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic                   done_q, cap_vld, cap_relu;
  logic [IN_WIDTH-1:0]    cap_data;
  logic [SHIFT_WIDTH-1:0] cap_shift;
  logic signed [IN_WIDTH-1:0] x, y;
  logic                   pos_ovf, neg_ovf;
  logic [OUT_WIDTH-1:0]   sat_val;
  logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   full, pop, accept, drop;
  always_comb begin
    x = (cap_relu && cap_data[IN_WIDTH-1]) ? '0 : cap_data;
    y = x >>> cap_shift;
    pos_ovf = !y[IN_WIDTH-1] && (|y[IN_WIDTH-2:OUT_WIDTH-1]);
    neg_ovf = y[IN_WIDTH-1] && !(&y[IN_WIDTH-2:OUT_WIDTH-1]);
    sat_val = pos_ovf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
              neg_ovf ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : y[OUT_WIDTH-1:0];
  end
  assign fifo_level = wr_ptr - rd_ptr;
  assign out_valid  = fifo_level != '0;
  // level never exceeds FIFO_DEPTH, so the MSB alone marks full
  assign full       = fifo_level[AW];
  assign out_data   = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign pop        = out_valid & out_ready;
  assign accept     = cap_vld & (!full | pop);
  assign drop       = cap_vld & full & !pop;
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q     <= 1'b0;
      cap_vld    <= 1'b0;
      cap_data   <= '0;
      cap_relu   <= 1'b0;
      cap_shift  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sat_flag   <= 1'b0;
      overflow   <= 1'b0;
      result_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      done_q  <= done & enable;
      cap_vld <= done_q;
      if (done_q) begin
        cap_data  <= in_data;
        cap_relu  <= relu_en;
        cap_shift <= shift_amt;
      end
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        result_cnt <= result_cnt + 1'b1;
        sat_flag   <= sat_flag | pos_ovf | neg_ovf;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (!(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) if (accept) mem[wr_ptr[AW-1:0]] <= sat_val;
endmodule

// File: tb/tb_cim_result_collector.sv
// tb_cim_result_collector: directed self-checking bench for the CIM result collector.
module tb_cim_result_collector;
  logic        clk = 1'b0, reset = 1'b1, done = 1'b0, enable = 1'b1, relu_en = 1'b0, out_ready = 1'b0;
  logic [21:0] in_data = '0;
  logic [4:0]  shift_amt = '0;
  logic        out_valid, sat_flag, overflow;
  logic [7:0]  out_data;
  logic [15:0] result_cnt, drop_cnt;
  logic [2:0]  fifo_level;
  int checks = 0, failures = 0;
  int seq [14];
  always #5 clk = ~clk;
  cim_result_collector dut (
    .clk(clk), .reset(reset), .done(done), .in_data(in_data), .enable(enable),
    .relu_en(relu_en), .shift_amt(shift_amt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .overflow(overflow), .result_cnt(result_cnt),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input int v, input int sh, input logic r);
    in_data = 22'(v);
    shift_amt = 5'(sh);
    relu_en = r;
    done = 1'b1;
    step;
    done = 1'b0;
    step;
    step;
  endtask
  initial begin
    step;
    step;
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_cnts", {result_cnt, drop_cnt}, 0);
    chk("rst_flags", {sat_flag, overflow}, 0);
    out_ready = 1'b1;
    send(1000, 3, 1'b0);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'd125);
    chk("t1_sat", 32'(sat_flag), 0);
    step;
    chk("t1_cnt", 32'(result_cnt), 1);
    chk("t1_empty", 32'(out_valid), 0);
    send(-5000, 2, 1'b0);
    chk("t2_sat_data", 32'(out_data), 32'h80);
    chk("t2_sat_flag", 32'(sat_flag), 1);
    step;
    send(-5000, 2, 1'b1);
    chk("t2_relu_data", 32'(out_data), 0);
    chk("t2_relu_sat", 32'(sat_flag), 1);
    step;
    send(-100, 1, 1'b0);
    chk("t2_neg_data", 32'(out_data), 32'hCE);
    step;
    send(-5, 1, 1'b0);
    chk("t2_floor_data", 32'(out_data), 32'hFD);
    step;
    chk("t2_cnt", 32'(result_cnt), 5);
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(i, 0, 1'b0);
    chk("t3_level", 32'(fifo_level), 4);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_drops", 32'(drop_cnt), 2);
    step;
    chk("t3_stable", 32'(out_data), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_pop", 32'(out_data), 32'(i));
      step;
    end
    chk("t3_drained", 32'(fifo_level), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(10 + i, 0, 1'b0);
    for (int i = 0; i < 4; i++) seq[i] = 10 + i;
    for (int i = 4; i < 14; i++) seq[i] = 97 + i;
    for (int j = 1; j <= 16; j++) begin
      done = (j <= 10);
      in_data = 22'(100 + j - 1);
      out_ready = (j >= 3);
      if (j >= 3) begin
        chk("t4_data", 32'(out_data), 32'(seq[j-3]));
        chk("t4_level", 32'(fifo_level), (j <= 13) ? 32'd4 : 32'(17 - j));
      end
      step;
    end
    done = 1'b0;
    chk("t4_empty", 32'(fifo_level), 0);
    chk("t4_drops", 32'(drop_cnt), 2);
    chk("t4_cnt", 32'(result_cnt), 23);
    in_data = 22'd77;
    done = 1'b1;
    step;
    done = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    step;
    step;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_cnts", {result_cnt, drop_cnt}, 0);
    chk("t5_flags", {sat_flag, overflow}, 0);
    chk("t5_level", 32'(fifo_level), 0);
    enable = 1'b0;
    send(5, 0, 1'b0);
    send(6, 0, 1'b0);
    chk("t6_blocked", 32'(out_valid), 0);
    chk("t6_blocked_cnt", 32'(result_cnt), 0);
    enable = 1'b1;
    in_data = 22'd9;
    done = 1'b1;
    step;
    enable = 1'b0;
    done = 1'b0;
    step;
    step;
    chk("t6_inflight_valid", 32'(out_valid), 1);
    chk("t6_inflight_data", 32'(out_data), 9);
    chk("t6_inflight_cnt", 32'(result_cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
